spi_mem_arbiter: RTL and testbench
==================================

// Module: spi_mem_arbiter
// PURPOSE
//  Shares the single spi_mem serial-memory engine between two requesters: the CPU
//  (fetch/data accesses sequenced by fsm) and a program loader/debug port. Holds
//  a one-transaction sequencer: it arbitrates, launches one spi_mem transfer,
//  waits for completion, then returns read data and an ack. It also produces a
//  CPU stall and a transfer timeout error.
// PARAMETERS
//  DW           16     data/address width
//  TIMEOUT      1024   max cycles from mem_start_o to completion before abort
//  LOADER_PRIO  0      1: loader always wins ties; 0: round-robin on ties
// PORTS
//  clk          in   1    system clock, all logic on rising edge
//  reset        in   1    asynchronous, active-high reset
//  cpu_req_i    in   1    CPU request; hold with addr/data/rwb stable until ack
//  cpu_rwb_i    in   1    1 = read, 0 = write
//  cpu_addr_i   in   DW   CPU byte address
//  cpu_wdata_i  in   DW   CPU write data
//  cpu_ack_o    out  1    one-cycle completion pulse to CPU
//  cpu_stall_o  out  1    cpu_req_i & ~cpu_ack_o (feeds fsm halt)
//  ld_req_i     in   1    loader request; same rules as CPU
//  ld_rwb_i     in   1    1 = read, 0 = write
//  ld_addr_i    in   DW   loader address
//  ld_wdata_i   in   DW   loader write data
//  ld_ack_o     out  1    one-cycle completion pulse to loader
//  rdata_o      out  DW   read data; valid on ack cycle, held until next ack
//  err_o        out  1    pulses with ack when the transfer timed out
//  mem_start_o  out  1    one-cycle start pulse to spi_mem
//  mem_rwb_o    out  1    registered rwb of granted requester
//  mem_addr_o   out  DW   registered address of granted requester
//  mem_wdata_o  out  DW   registered write data of granted requester
//  mem_busy_i   in   1    spi_mem busy (its halt output), high during transfer
//  mem_rdata_i  in   DW   spi_mem read data, valid when busy falls
// BEHAVIOUR
//  Reset: state IDLE; all acks, err_o, mem_start_o = 0; rdata_o, mem_addr_o,
//   mem_wdata_o = 0; mem_rwb_o = 1; last_grant = LOADER (CPU wins first tie).
//  FSM (one-hot or encoded, 5 states):
//   IDLE  : if any req sampled high -> pick winner, latch its rwb/addr/wdata
//           into mem_*_o and grant reg -> START.
//   START : mem_start_o = 1 for exactly this cycle; clear timeout counter -> WAIT.
//   WAIT  : wait for mem_busy_i = 1 -> XFER.
//   XFER  : wait for mem_busy_i = 0 -> capture mem_rdata_i into rdata_o (reads
//           only; writes leave rdata_o unchanged) -> DONE.
//   DONE  : ack_o of granted requester = 1 for this cycle; update last_grant -> IDLE.
//  Timeout: counter runs in WAIT and XFER; reaching TIMEOUT-1 goes to DONE with
//   err_o = 1 and rdata_o = all-ones for reads. Counter width = clog2(TIMEOUT)+1.
//  Arbitration: only one req -> it wins. Both -> LOADER_PRIO=1: loader; else the
//   requester not in last_grant. Grant fixed until DONE; no preemption.
//  Latency (no contention): req high at edge N -> mem_start_o high cycle N+1;
//   ack at earliest 2 cycles after mem_busy_i falls.
//  Back-to-back: requester keeping req high after ack is re-arbitrated in IDLE
//   the cycle after DONE; one idle cycle minimum between transactions.
//  Request withdrawn before grant: ignored. Withdrawn after grant: transfer
//   still completes and ack still pulses (requester must tolerate it).
//  Addresses are passed unmodified (no wrap, no alignment check).
//  Reset mid-transfer: immediate return to reset values; no ack issued;
//   spi_mem is reset by the same reset.
//  Never two acks in one cycle; mem_start_o never high outside START.
// TESTING
//  T1 CPU read 0x0010, spi_mem model returns 0xBEEF after 40 busy cycles ->
//     one mem_start_o, mem_addr_o=0x0010, cpu_ack_o one cycle, rdata_o=0xBEEF.
//  T2 Loader write 0x0200<=0x1234 while CPU idle -> mem_rwb_o=0,
//     mem_wdata_o=0x1234, ld_ack_o pulse, rdata_o unchanged, cpu_stall_o=0.
//  T3 Both req held 4 transactions, LOADER_PRIO=0 -> grant order CPU,LD,CPU,LD;
//     with LOADER_PRIO=1 -> LD,LD,LD,LD, cpu_stall_o high throughout.
//  T4 mem_busy_i never rises, TIMEOUT=16 -> ack + err_o at START+16 cycles,
//     read rdata_o=0xFFFF, FSM back in IDLE, next request served normally.
//  T5 reset pulsed during XFER -> all outputs at reset values same cycle, no
//     ack; after release CPU read completes correctly.
//  T6 CPU drops req in WAIT -> transfer finishes, cpu_ack_o still pulses once.

Source files
------------

// File: rtl/spi_mem_arbiter_if.sv
// Request/ack bundle shared by the CPU, the loader, the arbiter and the spi_mem engine.
interface spi_mem_arbiter_if #(
  parameter int DW = 16
);
  logic          cpu_req_i;
  logic          cpu_rwb_i;
  logic [DW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic          cpu_ack_o;
  logic          cpu_stall_o;
  logic          ld_req_i;
  logic          ld_rwb_i;
  logic [DW-1:0] ld_addr_i;
  logic [DW-1:0] ld_wdata_i;
  logic          ld_ack_o;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic          mem_start_o;
  logic          mem_rwb_o;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_busy_i;
  logic [DW-1:0] mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_rwb_i, cpu_addr_i, cpu_wdata_i,
    input  ld_req_i, ld_rwb_i, ld_addr_i, ld_wdata_i,
    input  mem_busy_i, mem_rdata_i,
    output cpu_ack_o, cpu_stall_o, ld_ack_o, rdata_o, err_o,
    output mem_start_o, mem_rwb_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_rwb_i, cpu_addr_i, cpu_wdata_i,
    output ld_req_i, ld_rwb_i, ld_addr_i, ld_wdata_i,
    output mem_busy_i, mem_rdata_i,
    input  cpu_ack_o, cpu_stall_o, ld_ack_o, rdata_o, err_o,
    input  mem_start_o, mem_rwb_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Two-requester sequencer in front of spi_mem: arbitrates CPU vs loader, runs one
// transfer at a time and returns an ack, read data and a timeout error.
module spi_mem_arbiter #(
  parameter int DW          = 16,
  parameter int TIMEOUT     = 1024,
  parameter bit LOADER_PRIO = 1'b0
) (
  input logic              clk,
  input logic              reset,
  spi_mem_arbiter_if.slave bus
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          GNT_CPU  = 1'b0;
  localparam logic          GNT_LD   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_grant;
  logic          r_last_grant;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_timeout;
  logic          w_ld_wins;
  logic          w_capture;
  logic          w_abort;
  logic          w_launch;
  logic          r_cpu_ack;
  logic          r_ld_ack;
  logic          r_err;
  logic          r_start;
  logic          r_rwb;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  assign w_cnt_inc = r_cnt + CNT_ONE;
  assign w_timeout = (w_cnt_inc >= CNT_LAST);
  assign w_launch  = (r_state == S_IDLE) && (w_state_nxt == S_START);

  // Tie-break: fixed loader priority, or the side that did not win last time.
  always_comb begin
    w_ld_wins = 1'b0;
    if (bus.ld_req_i && bus.cpu_req_i) begin
      w_ld_wins = LOADER_PRIO ? 1'b1 : (r_last_grant == GNT_CPU);
    end else if (bus.ld_req_i) begin
      w_ld_wins = 1'b1;
    end else begin
      w_ld_wins = 1'b0;
    end
  end

  // Sequencer next state; busy completion takes precedence over a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req_i || bus.ld_req_i) w_state_nxt = S_START;
        else                               w_state_nxt = S_IDLE;
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.mem_busy_i) begin
          w_state_nxt = S_XFER;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_XFER: begin
        if (!bus.mem_busy_i) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, timeout counter and grant bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CW{1'b0}};
      r_grant      <= GNT_CPU;
      r_last_grant <= GNT_LD;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_START) begin
        r_cnt <= {CW{1'b0}};
      end else if ((r_state == S_WAIT) || (r_state == S_XFER)) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_launch) begin
        r_grant <= w_ld_wins;
      end
      if (r_state == S_DONE) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // Registered outputs: launch pulse, granted request fields, acks, error and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start   <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_ld_ack  <= 1'b0;
      r_err     <= 1'b0;
      r_rwb     <= 1'b1;
      r_addr    <= {DW{1'b0}};
      r_wdata   <= {DW{1'b0}};
      r_rdata   <= {DW{1'b0}};
    end else begin
      r_start   <= (w_state_nxt == S_START);
      r_cpu_ack <= (w_state_nxt == S_DONE) && (r_grant == GNT_CPU);
      r_ld_ack  <= (w_state_nxt == S_DONE) && (r_grant == GNT_LD);
      r_err     <= w_abort;
      if (w_launch) begin
        r_rwb   <= w_ld_wins ? bus.ld_rwb_i   : bus.cpu_rwb_i;
        r_addr  <= w_ld_wins ? bus.ld_addr_i  : bus.cpu_addr_i;
        r_wdata <= w_ld_wins ? bus.ld_wdata_i : bus.cpu_wdata_i;
      end
      if (w_capture && r_rwb) begin
        r_rdata <= bus.mem_rdata_i;
      end else if (w_abort && r_rwb) begin
        r_rdata <= {DW{1'b1}};
      end
    end
  end

  assign bus.cpu_ack_o   = r_cpu_ack;
  assign bus.ld_ack_o    = r_ld_ack;
  assign bus.cpu_stall_o = bus.cpu_req_i & ~r_cpu_ack;
  assign bus.err_o       = r_err;
  assign bus.rdata_o     = r_rdata;
  assign bus.mem_start_o = r_start;
  assign bus.mem_rwb_o   = r_rwb;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: two instances (round-robin / TIMEOUT 1024 and
// loader-priority / TIMEOUT 16), each with a behavioural spi_mem responder and a scoreboard.
module tb_spi_mem_arbiter;

  typedef struct {
    int          d;
    bit          ld;
    bit          rwb;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          err;
  } exp_t;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;
  int   ack_cyc = 0;
  exp_t sb[$];

  logic [15:0] mem0 [int];
  logic [15:0] mem1 [int];
  int   m0_len = 40, m0_cnt = 0, starts0 = 0, start_cyc0 = 0;
  int   m1_len = 5,  m1_cnt = 0, starts1 = 0, start_cyc1 = 0;
  bit   m0_stuck = 1'b0, m1_stuck = 1'b0;
  bit   m0_rwb = 1'b1, m1_rwb = 1'b1;
  logic [15:0] m0_addr = 16'h0000, m1_addr = 16'h0000;

  spi_mem_arbiter_if #(.DW(16)) if0 ();
  spi_mem_arbiter_if #(.DW(16)) if1 ();

  spi_mem_arbiter #(.DW(16), .TIMEOUT(1024), .LOADER_PRIO(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .bus(if0.slave));
  spi_mem_arbiter #(.DW(16), .TIMEOUT(16), .LOADER_PRIO(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .bus(if1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // spi_mem responder for dut0: busy for m0_len cycles after each start, data when busy drops.
  always @(negedge clk) begin
    if (rst0) begin
      if0.mem_busy_i  = 1'b0;
      if0.mem_rdata_i = 16'h0000;
      m0_cnt = 0;
    end else begin
      if (if0.mem_start_o) begin
        starts0++;
        start_cyc0 = cyc;
      end
      if (m0_cnt != 0) begin
        m0_cnt--;
        if (m0_cnt == 0) begin
          if0.mem_busy_i = 1'b0;
          if (m0_rwb) if0.mem_rdata_i = mem0[int'(m0_addr)];
        end
      end else if (if0.mem_start_o && !m0_stuck) begin
        if0.mem_busy_i  = 1'b1;
        if0.mem_rdata_i = 16'h5A5A;
        m0_cnt  = m0_len;
        m0_addr = if0.mem_addr_o;
        m0_rwb  = if0.mem_rwb_o;
        if (!if0.mem_rwb_o) mem0[int'(if0.mem_addr_o)] = if0.mem_wdata_o;
      end
    end
  end

  // Same responder for dut1.
  always @(negedge clk) begin
    if (rst1) begin
      if1.mem_busy_i  = 1'b0;
      if1.mem_rdata_i = 16'h0000;
      m1_cnt = 0;
    end else begin
      if (if1.mem_start_o) begin
        starts1++;
        start_cyc1 = cyc;
      end
      if (m1_cnt != 0) begin
        m1_cnt--;
        if (m1_cnt == 0) begin
          if1.mem_busy_i = 1'b0;
          if (m1_rwb) if1.mem_rdata_i = mem1[int'(m1_addr)];
        end
      end else if (if1.mem_start_o && !m1_stuck) begin
        if1.mem_busy_i  = 1'b1;
        if1.mem_rdata_i = 16'h5A5A;
        m1_cnt  = m1_len;
        m1_addr = if1.mem_addr_o;
        m1_rwb  = if1.mem_rwb_o;
        if (!if1.mem_rwb_o) mem1[int'(if1.mem_addr_o)] = if1.mem_wdata_o;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input bit ld, input bit rwb,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (d == 0 && !ld) begin
      if0.cpu_rwb_i = rwb; if0.cpu_addr_i = addr; if0.cpu_wdata_i = wdata; if0.cpu_req_i = 1'b1;
    end else if (d == 0) begin
      if0.ld_rwb_i = rwb; if0.ld_addr_i = addr; if0.ld_wdata_i = wdata; if0.ld_req_i = 1'b1;
    end else if (!ld) begin
      if1.cpu_rwb_i = rwb; if1.cpu_addr_i = addr; if1.cpu_wdata_i = wdata; if1.cpu_req_i = 1'b1;
    end else begin
      if1.ld_rwb_i = rwb; if1.ld_addr_i = addr; if1.ld_wdata_i = wdata; if1.ld_req_i = 1'b1;
    end
  endtask

  task automatic drop(input int d, input bit ld);
    if (d == 0 && !ld)  if0.cpu_req_i = 1'b0;
    else if (d == 0)    if0.ld_req_i  = 1'b0;
    else if (!ld)       if1.cpu_req_i = 1'b0;
    else                if1.ld_req_i  = 1'b0;
  endtask

  task automatic push_exp(input int d, input bit ld, input bit rwb, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata, input bit err);
    exp_t e;
    e.d = d; e.ld = ld; e.rwb = rwb; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next ack on the expected instance and checks it against the scoreboard.
  task automatic expect_ack(input int budget);
    exp_t e;
    bit   seen;
    logic ca, la;
    int   n;
    e = sb.pop_front();
    seen = 1'b0; n = 0; ca = 1'b0; la = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      ca = (e.d == 0) ? if0.cpu_ack_o : if1.cpu_ack_o;
      la = (e.d == 0) ? if0.ld_ack_o  : if1.ld_ack_o;
      seen = ca | la;
    end
    chk("ack_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      ack_cyc = cyc;
      chk("ack_who", {30'd0, ca, la}, e.ld ? 32'd1 : 32'd2);
      chk("mem_rwb", (e.d == 0) ? {31'd0, if0.mem_rwb_o} : {31'd0, if1.mem_rwb_o}, {31'd0, e.rwb});
      chk("mem_addr", (e.d == 0) ? {16'd0, if0.mem_addr_o} : {16'd0, if1.mem_addr_o}, {16'd0, e.addr});
      if (!e.rwb) begin
        chk("mem_wdata", (e.d == 0) ? {16'd0, if0.mem_wdata_o} : {16'd0, if1.mem_wdata_o},
            {16'd0, e.wdata});
      end
      chk("rdata", (e.d == 0) ? {16'd0, if0.rdata_o} : {16'd0, if1.rdata_o}, {16'd0, e.rdata});
      chk("err", (e.d == 0) ? {31'd0, if0.err_o} : {31'd0, if1.err_o}, {31'd0, e.err});
      @(negedge clk);
      chk("ack_width", (e.d == 0) ? {30'd0, if0.cpu_ack_o, if0.ld_ack_o}
                                  : {30'd0, if1.cpu_ack_o, if1.ld_ack_o}, 32'd0);
    end
  endtask

  initial begin
    int base;
    int acks;
    if0.cpu_req_i = 1'b0; if0.cpu_rwb_i = 1'b1; if0.cpu_addr_i = 16'h0000; if0.cpu_wdata_i = 16'h0000;
    if0.ld_req_i  = 1'b0; if0.ld_rwb_i  = 1'b1; if0.ld_addr_i  = 16'h0000; if0.ld_wdata_i  = 16'h0000;
    if1.cpu_req_i = 1'b0; if1.cpu_rwb_i = 1'b1; if1.cpu_addr_i = 16'h0000; if1.cpu_wdata_i = 16'h0000;
    if1.ld_req_i  = 1'b0; if1.ld_rwb_i  = 1'b1; if1.ld_addr_i  = 16'h0000; if1.ld_wdata_i  = 16'h0000;
    mem0[16'h0010] = 16'hBEEF; mem0[16'h0100] = 16'h2222; mem0[16'h0300] = 16'h4444;
    mem1[16'h0100] = 16'h1111; mem1[16'h0300] = 16'h3333; mem1[16'h0050] = 16'h5555;
    mem1[16'h0040] = 16'h0404;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_start",  {31'd0, if0.mem_start_o}, 32'd0);
    chk("rst_acks",   {30'd0, if0.cpu_ack_o, if0.ld_ack_o}, 32'd0);
    chk("rst_err",    {31'd0, if0.err_o}, 32'd0);
    chk("rst_rwb",    {31'd0, if0.mem_rwb_o}, 32'd1);
    chk("rst_addr",   {16'd0, if0.mem_addr_o}, 32'd0);
    chk("rst_rdata",  {16'd0, if0.rdata_o}, 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // T1 CPU read
    base = starts0;
    drive(0, 1'b0, 1'b1, 16'h0010, 16'h0000);
    push_exp(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    @(negedge clk);
    chk("t1_start_latency", {31'd0, if0.mem_start_o}, 32'd1);
    expect_ack(200);
    chk("t1_one_start", starts0 - base, 32'd1);
    drop(0, 1'b0);

    // T2 loader write, CPU idle
    drive(0, 1'b1, 1'b0, 16'h0200, 16'h1234);
    push_exp(0, 1'b1, 1'b0, 16'h0200, 16'h1234, 16'hBEEF, 1'b0);
    @(negedge clk);
    chk("t2_start", {31'd0, if0.mem_start_o}, 32'd1);
    chk("t2_cpu_stall", {31'd0, if0.cpu_stall_o}, 32'd0);
    expect_ack(200);
    drop(0, 1'b1);
    @(negedge clk);

    // T3a both held, round robin: CPU, LD, CPU, LD
    drive(0, 1'b0, 1'b1, 16'h0100, 16'h0000);
    drive(0, 1'b1, 1'b1, 16'h0300, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      push_exp(0, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'h2222, 1'b0);
      push_exp(0, 1'b1, 1'b1, 16'h0300, 16'h0000, 16'h4444, 1'b0);
    end
    for (int i = 0; i < 4; i++) expect_ack(200);
    drop(0, 1'b0); drop(0, 1'b1);

    // T3b both held, loader priority: LD x4 with CPU stalled, then CPU
    drive(1, 1'b0, 1'b1, 16'h0100, 16'h0000);
    drive(1, 1'b1, 1'b1, 16'h0300, 16'h0000);
    for (int i = 0; i < 4; i++) push_exp(1, 1'b1, 1'b1, 16'h0300, 16'h0000, 16'h3333, 1'b0);
    for (int i = 0; i < 4; i++) begin
      expect_ack(100);
      chk("t3b_cpu_stall", {31'd0, if1.cpu_stall_o}, 32'd1);
    end
    drop(1, 1'b1);
    push_exp(1, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'h1111, 1'b0);
    expect_ack(100);
    drop(1, 1'b0);

    // T4 timeout on dut1 (busy never rises), then a normal read
    m1_stuck = 1'b1;
    drive(1, 1'b0, 1'b1, 16'h0040, 16'h0000);
    push_exp(1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'hFFFF, 1'b1);
    expect_ack(60);
    chk("t4_timeout_latency", ack_cyc - start_cyc1, 32'd16);
    drop(1, 1'b0);
    m1_stuck = 1'b0;
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 16'h0050, 16'h0000);
    push_exp(1, 1'b0, 1'b1, 16'h0050, 16'h0000, 16'h5555, 1'b0);
    @(negedge clk);
    chk("t4_restart_latency", {31'd0, if1.mem_start_o}, 32'd1);
    expect_ack(100);
    drop(1, 1'b0);

    // T6 CPU withdraws request in WAIT; ack still pulses exactly once
    m0_len = 10;
    drive(0, 1'b0, 1'b1, 16'h0100, 16'h0000);
    push_exp(0, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'h2222, 1'b0);
    repeat (2) @(negedge clk);
    drop(0, 1'b0);
    #1;
    chk("t6_stall_dropped", {31'd0, if0.cpu_stall_o}, 32'd0);
    expect_ack(100);
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      acks += int'(if0.cpu_ack_o);
    end
    chk("t6_no_extra_ack", acks, 32'd0);

    // T5 reset during XFER, then a clean read
    m0_len = 40;
    drive(0, 1'b0, 1'b1, 16'h0300, 16'h0000);
    repeat (10) @(negedge clk);
    rst0 = 1'b1;
    #1;
    chk("t5_start",  {31'd0, if0.mem_start_o}, 32'd0);
    chk("t5_err",    {31'd0, if0.err_o}, 32'd0);
    chk("t5_rwb",    {31'd0, if0.mem_rwb_o}, 32'd1);
    chk("t5_addr",   {16'd0, if0.mem_addr_o}, 32'd0);
    chk("t5_wdata",  {16'd0, if0.mem_wdata_o}, 32'd0);
    chk("t5_rdata",  {16'd0, if0.rdata_o}, 32'd0);
    drop(0, 1'b0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(if0.cpu_ack_o) + int'(if0.ld_ack_o);
    end
    chk("t5_no_ack", acks, 32'd0);
    rst0 = 1'b0;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0010, 16'h0000);
    push_exp(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    @(negedge clk);
    chk("t5_restart_latency", {31'd0, if0.mem_start_o}, 32'd1);
    expect_ack(200);
    drop(0, 1'b0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
